// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: pipeline hazard controller for the 5-stage core.
// Forwards M/W results to NSRC E-stage operands, detects load-use, branch
// and long-latency (multiply) hazards, tracks one in-flight long op and
// counts decode-stall cycles with saturation.
// Ports:
//   Clk, Reset            clock (rising edge), synchronous active-low reset
//   RegWriteM/W, WA3E/M/W write enables and destinations per stage
//   MemToRegE             load in E
//   BranchTakenE, PCSrcD/E/M/W  branch and PC-write flags per stage
//   RAD, RAE, UseD        packed D/E source indices, D source valid mask
//   LongOpD, LongOpE      long-latency op in D, in E
//   FowardE               per-source operand select (10 = M, 01 = W, 00 = RF)
//   StallF, StallD, FlushD, FlushE  pipeline register control
//   LongBusy, LongWA, LongDone      long-op scoreboard status
//   StallCount            saturating count of StallD cycles
module hazard_ctrl_mc #(
    parameter int unsigned REG_BITS = 4,
    parameter int unsigned NSRC     = 3,
    parameter int unsigned MUL_LAT  = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       RegWriteM,
    input  logic                       RegWriteW,
    input  logic                       MemToRegE,
    input  logic                       BranchTakenE,
    input  logic                       PCSrcD,
    input  logic                       PCSrcE,
    input  logic                       PCSrcM,
    input  logic                       PCSrcW,
    input  logic [NSRC*REG_BITS-1:0]   RAD,
    input  logic [NSRC*REG_BITS-1:0]   RAE,
    input  logic [NSRC-1:0]            UseD,
    input  logic [REG_BITS-1:0]        WA3E,
    input  logic [REG_BITS-1:0]        WA3M,
    input  logic [REG_BITS-1:0]        WA3W,
    input  logic                       LongOpD,
    input  logic                       LongOpE,
    output logic [2*NSRC-1:0]          FowardE,
    output logic                       StallF,
    output logic                       StallD,
    output logic                       FlushD,
    output logic                       FlushE,
    output logic                       LongBusy,
    output logic [REG_BITS-1:0]        LongWA,
    output logic                       LongDone,
    output logic [CNT_W-1:0]           StallCount
);

    localparam int unsigned LCNT_W = 3;
    localparam logic [LCNT_W-1:0] LAT_LOAD = LCNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } sb_state_t;

    sb_state_t             state, state_n;
    logic [LCNT_W-1:0]     lcnt, lcnt_n;
    logic [REG_BITS-1:0]   lwa, lwa_n;
    logic [CNT_W-1:0]      stall_cnt, stall_cnt_n;

    logic [2*NSRC-1:0]     fwd;
    logic                  ldr_match, raw_match;
    logic                  busy, done;
    logic                  ldr_stall, long_raw, long_struct;
    logic                  pc_wr_pending, stall_d;

    // Per-source forwarding select and D-stage source matches
    always_comb begin
        fwd       = '0;
        ldr_match = 1'b0;
        raw_match = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (RegWriteM && (RAE[i*REG_BITS +: REG_BITS] == WA3M)) begin
                fwd[2*i +: 2] = 2'b10;
            end else if (RegWriteW && (RAE[i*REG_BITS +: REG_BITS] == WA3W)) begin
                fwd[2*i +: 2] = 2'b01;
            end
            if (UseD[i] && (RAD[i*REG_BITS +: REG_BITS] == WA3E)) begin
                ldr_match = 1'b1;
            end
            if (UseD[i] && (RAD[i*REG_BITS +: REG_BITS] == lwa)) begin
                raw_match = 1'b1;
            end
        end
    end

    // Hazard decisions
    always_comb begin
        busy          = (state == S_BUSY);
        done          = busy && (lcnt == LCNT_W'(1));
        ldr_stall     = MemToRegE && ldr_match;
        long_raw      = busy && raw_match;
        // A long op in D may advance in the LongDone cycle (cnt == 1)
        long_struct   = LongOpD && busy && (lcnt > LCNT_W'(1));
        pc_wr_pending = PCSrcD || PCSrcE || PCSrcM;
        stall_d       = ldr_stall || long_raw || long_struct;
    end

    // Scoreboard and counter state registers
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= S_IDLE;
            lcnt      <= '0;
            lwa       <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_n;
            lcnt      <= lcnt_n;
            lwa       <= lwa_n;
            stall_cnt <= stall_cnt_n;
        end
    end

    // Scoreboard next state: a new load wins over the end-of-op clear
    always_comb begin
        state_n     = state;
        lcnt_n      = lcnt;
        lwa_n       = lwa;
        stall_cnt_n = stall_cnt;
        if (LongOpE) begin
            state_n = S_BUSY;
            lcnt_n  = LAT_LOAD;
            lwa_n   = WA3E;
        end else begin
            case (state)
                S_IDLE: begin
                    lcnt_n = '0;
                end
                S_BUSY: begin
                    if (lcnt <= LCNT_W'(1)) begin
                        state_n = S_IDLE;
                        lcnt_n  = '0;
                    end else begin
                        lcnt_n = lcnt - LCNT_W'(1);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    lcnt_n  = '0;
                end
            endcase
        end
        if (stall_d && (stall_cnt != CNT_MAX)) begin
            stall_cnt_n = stall_cnt + CNT_W'(1);
        end
    end

    // All outputs held at zero while Reset is low
    always_comb begin
        FowardE    = Reset ? fwd : '0;
        StallD     = Reset && stall_d;
        StallF     = Reset && (stall_d || pc_wr_pending);
        FlushE     = Reset && (stall_d || BranchTakenE);
        FlushD     = Reset && (pc_wr_pending || PCSrcW || BranchTakenE);
        LongBusy   = Reset && busy;
        LongDone   = Reset && done;
        LongWA     = Reset ? lwa : '0;
        StallCount = Reset ? stall_cnt : '0;
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: directed self-checking bench for hazard_ctrl_mc.
// A second instance with CNT_W=2 shares all inputs to exercise saturation.
module tb_hazard_ctrl_mc;

    localparam int unsigned RB = 4;
    localparam int unsigned NS = 3;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            RegWriteM, RegWriteW, MemToRegE, BranchTakenE;
    logic            PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic [NS*RB-1:0] RAD, RAE;
    logic [NS-1:0]   UseD;
    logic [RB-1:0]   WA3E, WA3M, WA3W;
    logic            LongOpD, LongOpE;

    logic [2*NS-1:0] FowardE;
    logic            StallF, StallD, FlushD, FlushE, LongBusy, LongDone;
    logic [RB-1:0]   LongWA;
    logic [15:0]     StallCount;

    logic [2*NS-1:0] s_FowardE;
    logic            s_StallF, s_StallD, s_FlushD, s_FlushE, s_LongBusy, s_LongDone;
    logic [RB-1:0]   s_LongWA;
    logic [1:0]      s_StallCount;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    hazard_ctrl_mc #(.REG_BITS(RB), .NSRC(NS), .MUL_LAT(3), .CNT_W(16)) u_dut (
        .Clk(Clk), .Reset(Reset), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .BranchTakenE(BranchTakenE), .PCSrcD(PCSrcD),
        .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .RAD(RAD), .RAE(RAE),
        .UseD(UseD), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .LongOpD(LongOpD),
        .LongOpE(LongOpE), .FowardE(FowardE), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE), .LongBusy(LongBusy), .LongWA(LongWA),
        .LongDone(LongDone), .StallCount(StallCount)
    );

    hazard_ctrl_mc #(.REG_BITS(RB), .NSRC(NS), .MUL_LAT(3), .CNT_W(2)) u_dut_sat (
        .Clk(Clk), .Reset(Reset), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .BranchTakenE(BranchTakenE), .PCSrcD(PCSrcD),
        .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .RAD(RAD), .RAE(RAE),
        .UseD(UseD), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .LongOpD(LongOpD),
        .LongOpE(LongOpE), .FowardE(s_FowardE), .StallF(s_StallF), .StallD(s_StallD),
        .FlushD(s_FlushD), .FlushE(s_FlushE), .LongBusy(s_LongBusy), .LongWA(s_LongWA),
        .LongDone(s_LongDone), .StallCount(s_StallCount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic clear_inputs();
        RegWriteM = 0; RegWriteW = 0; MemToRegE = 0; BranchTakenE = 0;
        PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
        RAD = '0; RAE = '0; UseD = '0; WA3E = '0; WA3M = '0; WA3W = '0;
        LongOpD = 0; LongOpE = 0;
    endtask

    // Load-use hazard on source 1 against register 7
    task automatic set_load_use();
        MemToRegE = 1; WA3E = 4'd7; RAD = {4'd0, 4'd7, 4'd0}; UseD = 3'b010;
    endtask

    initial begin
        clear_inputs();
        Reset = 0;
        // Outputs forced low during reset even with hazards present
        set_load_use();
        RegWriteM = 1; WA3M = 4'd0; PCSrcE = 1; BranchTakenE = 1;
        #1;
        check("rst_fwd", 32'(FowardE), 32'h0);
        check("rst_stalld", 32'(StallD), 32'h0);
        check("rst_stallf", 32'(StallF), 32'h0);
        check("rst_flushd", 32'(FlushD), 32'h0);
        check("rst_flushe", 32'(FlushE), 32'h0);
        tick();
        tick();
        check("rst_busy", 32'(LongBusy), 32'h0);
        check("rst_cnt", 32'(StallCount), 32'h0);
        clear_inputs();
        Reset = 1;
        #1;
        check("idle_stalld", 32'(StallD), 32'h0);
        check("idle_lwa", 32'(LongWA), 32'h0);

        // Forwarding, M over W priority
        RAE = {4'd5, 4'd3, 4'd3}; WA3M = 4'd3; RegWriteM = 1; WA3W = 4'd5; RegWriteW = 1;
        #1;
        check("fwd_mw", 32'(FowardE), 32'(6'b01_10_10));
        RegWriteM = 0;
        #1;
        check("fwd_w_only", 32'(FowardE), 32'(6'b01_00_00));
        RAE = {4'd3, 4'd3, 4'd3}; WA3W = 4'd3; RegWriteM = 1;
        #1;
        check("fwd_prio", 32'(FowardE), 32'(6'b10_10_10));
        clear_inputs();

        // Load-use
        set_load_use();
        #1;
        check("lu_stalld", 32'(StallD), 32'h1);
        check("lu_stallf", 32'(StallF), 32'h1);
        check("lu_flushe", 32'(FlushE), 32'h1);
        check("lu_flushd", 32'(FlushD), 32'h0);
        UseD = 3'b001;
        #1;
        check("lu_unused_stalld", 32'(StallD), 32'h0);
        check("lu_unused_stallf", 32'(StallF), 32'h0);
        check("lu_unused_flushe", 32'(FlushE), 32'h0);
        // Stall together with a taken branch
        UseD = 3'b010; BranchTakenE = 1;
        #1;
        check("lu_br_flushe", 32'(FlushE), 32'h1);
        check("lu_br_flushd", 32'(FlushD), 32'h1);
        check("lu_br_stallf", 32'(StallF), 32'h1);
        BranchTakenE = 0;

        // Counter: 5 then 6 stall cycles; the 2-bit copy saturates at 3
        for (int k = 0; k < 5; k++) tick();
        check("cnt_5", 32'(StallCount), 32'd5);
        check("sat_5", 32'(s_StallCount), 32'd3);
        tick();
        check("cnt_6", 32'(StallCount), 32'd6);
        check("sat_6", 32'(s_StallCount), 32'd3);
        clear_inputs();
        #1;

        // Isolated long op to r9 with a dependent D-stage source
        LongOpE = 1; WA3E = 4'd9;
        #1;
        check("lop_pre_busy", 32'(LongBusy), 32'h0);
        tick();
        LongOpE = 0; RAD = {4'd0, 4'd0, 4'd9}; UseD = 3'b001;
        // Load-use on the same register: one stall, one count
        MemToRegE = 1; WA3E = 4'd9;
        #1;
        check("lop1_busy", 32'(LongBusy), 32'h1);
        check("lop1_wa", 32'(LongWA), 32'd9);
        check("lop1_done", 32'(LongDone), 32'h0);
        check("lop1_stalld", 32'(StallD), 32'h1);
        tick();
        MemToRegE = 0; WA3E = 4'd0;
        #1;
        check("lop2_busy", 32'(LongBusy), 32'h1);
        check("lop2_done", 32'(LongDone), 32'h0);
        check("lop2_stalld", 32'(StallD), 32'h1);
        tick();
        check("lop3_busy", 32'(LongBusy), 32'h1);
        check("lop3_done", 32'(LongDone), 32'h1);
        check("lop3_stalld", 32'(StallD), 32'h1);
        tick();
        check("lop4_busy", 32'(LongBusy), 32'h0);
        check("lop4_done", 32'(LongDone), 32'h0);
        check("lop4_stalld", 32'(StallD), 32'h0);
        check("lop_cnt", 32'(StallCount), 32'd9);
        clear_inputs();

        // Structural hazard and back-to-back reload
        LongOpE = 1; WA3E = 4'd4;
        tick();
        LongOpE = 0; LongOpD = 1;
        #1;
        check("st_cnt3_stalld", 32'(StallD), 32'h1);
        tick();
        check("st_cnt2_stalld", 32'(StallD), 32'h1);
        tick();
        check("st_cnt1_stalld", 32'(StallD), 32'h0);
        check("st_cnt1_done", 32'(LongDone), 32'h1);
        LongOpD = 0; LongOpE = 1; WA3E = 4'd6;
        tick();
        LongOpE = 0;
        check("st_reload_busy", 32'(LongBusy), 32'h1);
        check("st_reload_wa", 32'(LongWA), 32'd6);
        check("st_reload_done", 32'(LongDone), 32'h0);
        check("st_cnt", 32'(StallCount), 32'd11);
        tick();
        tick();
        check("st_reload_last", 32'(LongDone), 32'h1);
        tick();

        // Reset in the middle of a long op
        LongOpE = 1; WA3E = 4'd8;
        tick();
        LongOpE = 0;
        check("mr_busy", 32'(LongBusy), 32'h1);
        Reset = 0;
        set_load_use();
        #1;
        check("mr_forced_busy", 32'(LongBusy), 32'h0);
        check("mr_forced_stalld", 32'(StallD), 32'h0);
        check("mr_forced_cnt", 32'(StallCount), 32'h0);
        tick();
        clear_inputs();
        Reset = 1;
        #1;
        check("mr_after_busy", 32'(LongBusy), 32'h0);
        check("mr_after_cnt", 32'(StallCount), 32'h0);
        check("mr_after_lwa", 32'(LongWA), 32'h0);
        for (int k = 0; k < 3; k++) begin
            check("mr_no_done", 32'(LongDone), 32'h0);
            tick();
        end

        // Branch flags
        PCSrcE = 1;
        #1;
        check("br_pce_stallf", 32'(StallF), 32'h1);
        check("br_pce_flushd", 32'(FlushD), 32'h1);
        check("br_pce_stalld", 32'(StallD), 32'h0);
        check("br_pce_flushe", 32'(FlushE), 32'h0);
        PCSrcE = 0; BranchTakenE = 1;
        #1;
        check("br_bt_flushe", 32'(FlushE), 32'h1);
        check("br_bt_flushd", 32'(FlushD), 32'h1);
        check("br_bt_stallf", 32'(StallF), 32'h0);
        BranchTakenE = 0; PCSrcW = 1;
        #1;
        check("br_pcw_flushd", 32'(FlushD), 32'h1);
        check("br_pcw_stallf", 32'(StallF), 32'h0);
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised pipeline hazard controller for the 5-stage core, successor to the fixed two-source hazard unit. It forwards from the M and W stages for NSRC source operands and produces stall/flush for load-use and branch hazards. It also adds a sequential scoreboard for one in-flight long-latency (multiply) operation, with structural and RAW stalls, plus a saturating stall-cycle counter. It sits beside the pipeline registers and drives their enable/clear inputs and the E-stage operand muxes.

## Interface
- REG_BITS, 4, register index width
- NSRC, 3, source operands per instruction (1..4)
- MUL_LAT, 3, cycles a long op occupies the unit after leaving E (1..7)
- CNT_W, 16, stall counter width
- Clk  in  1  clock, rising edge
- Reset  in  1  reset, synchronous, active-low (Reset=0 resets)
- RegWriteM, RegWriteW  in  1  write enables of instructions in M, W
- MemToRegE  in  1  load in E
- BranchTakenE, PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  branch/PC-write flags per stage
- RAD, RAE  in  NSRC*REG_BITS  packed sources in D, E; source i at [i*REG_BITS +: REG_BITS]
- UseD  in  NSRC  per-source valid mask for D; an unused source never causes a stall
- WA3E, WA3M, WA3W  in  REG_BITS  destinations in E, M, W
- LongOpD, LongOpE  in  1  long-latency op in D, in E
- FowardE  out  2*NSRC  per-source mux select at [2i+1:2i]: 10 = M, 01 = W, 00 = register file
- StallF, StallD, FlushD, FlushE  out  1  pipeline control
- LongBusy  out  1  long op in flight
- LongWA  out  REG_BITS  destination of the in-flight long op
- LongDone  out  1  last busy cycle; result is written back this cycle
- StallCount  out  CNT_W  saturating count of StallD cycles

## Operation
- Forwarding (combinational), per source i:
  - 10 if RAE[i]==WA3M and RegWriteM.
  - Else 01 if RAE[i]==WA3W and RegWriteW.
  - Else 00.
  - M has priority over W.
- LDRStall = MemToRegE and any i with UseD[i] and RAD[i]==WA3E.
- LongRAW = LongBusy and any i with UseD[i] and RAD[i]==LongWA.
- LongStruct = LongOpD and LongBusy and cnt>1. A long op in D may advance in the LongDone cycle.
- PCWrPendingF = PCSrcD | PCSrcE | PCSrcM.
- StallD = LDRStall | LongRAW | LongStruct.
- StallF = StallD | PCWrPendingF.
- FlushE = StallD | BranchTakenE.
- FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
- Scoreboard state: busy bit, 3-bit cnt, LongWA register.
  - IDLE→BUSY: when LongOpE=1 at a clock edge, load cnt=MUL_LAT, LongWA=WA3E, busy=1.
  - BUSY: cnt decrements each cycle. LongDone = busy & cnt==1. At the edge after LongDone, busy=0 unless LongOpE=1 that cycle.
  - LongOpE=1 in the LongDone cycle: new op loads; busy stays 1 with no idle gap. Load takes priority over clear.
  - LongOpE=1 while cnt>1 is unreachable (LongStruct). If it occurs anyway, the new op overwrites (last-writer wins).
- StallCount increments at each edge with StallD=1 and saturates at 2^CNT_W-1.

## Timing
- Forwarding and stall/flush outputs are combinational, with zero-cycle latency from inputs.
- Scoreboard and counter update on the rising Clk edge. LongBusy rises the cycle after LongOpE and stays high exactly MUL_LAT cycles for an isolated op.
- Reset=0 sampled at an edge clears busy, cnt, LongWA and StallCount to 0.
- While Reset=0, every output is forced to 0: FowardE=0, stalls/flushes=0, LongBusy=0, LongDone=0. This holds even if inputs would assert them.
- Reset mid-operation aborts the in-flight long op with no LongDone pulse. Operation resumes the cycle after Reset returns to 1.
- Simultaneous LDRStall and LongRAW: StallD=1 once and StallCount increments by 1.
- Simultaneous StallD and BranchTakenE: FlushE=1, FlushD=1, StallF=1.
- Counter at saturation stays at all-ones.

## Test plan
- Forwarding: RAE={5,3,3}, WA3M=3 with RegWriteM=1, WA3W=5 with RegWriteW=1 -> FowardE = {01,10,10}. Same with RegWriteM=0 -> {01,00,00}.
- Load-use: MemToRegE=1, WA3E=7, RAD[1]=7, UseD=3'b010 -> StallD=StallF=FlushE=1, FlushD=0. With UseD=3'b001 -> all stall outputs 0.
- Long op (MUL_LAT=3): LongOpE=1 with WA3E=9 for one cycle -> LongBusy=1 for 3 cycles and LongWA=9. LongDone=1 in the 3rd busy cycle. RAD[0]=9 with UseD[0]=1 during those cycles -> StallD=1 in all 3 cycles.
- Structural: second LongOpD=1 during busy cnt=3,2 -> StallD=1. At cnt=1 -> StallD=0; LongOpE at the next edge reloads with no idle cycle.
- Branch: PCSrcE=1 -> StallF=1, FlushD=1, StallD=0. BranchTakenE=1 -> FlushE=1, FlushD=1.
- Reset/counter: hold a load-use stall for 5 cycles -> StallCount=5. Drive Reset=0 for one edge mid long op -> StallCount=0, LongBusy=0, no LongDone. With CNT_W=2 and 6 stall cycles -> StallCount=3.
